// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default parameters and parity helper
package uart_pkg;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int MAX_DATA_W       = 9;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake plus serial line and status of the transmitter
interface uart_tx_if import uart_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx;
    logic              busy;

    modport master (output tx_data, tx_valid, input tx_ready, tx, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx, busy);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with clear/enable, pulses bit_tick_o in the last cycle of each bit
module uart_baud_gen import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_tick_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = en_i && cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb cnt_d = (clr_i || bit_tick_o) ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: frames words into start/data(LSB first)/stop serial bits on a registered line.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx import uart_pkg::*; #(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus
);
    localparam int BW = $clog2(DATA_W);

    uart_state_e       state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_q;
    logic              tx_q;
    logic              ready_q;
    logic              tick;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    // The counter is held clear in IDLE so every frame starts on a full bit period
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q == IDLE),
        .en_i       (state_q != IDLE),
        .bit_tick_o (tick)
    );

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ready_q;
    assign bus.busy     = !ready_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.tx_valid) begin
                    shift_q <= bus.tx_data;
                    state_q <= START;
                    tx_q    <= 1'b0;
                    ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_q   <= even_parity(MAX_DATA_W'(bus.tx_data));
`endif
                end
                START: if (tick) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                end
                DATA: if (tick) begin
                    shift_q <= shift_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_q <= PARITY;
                        tx_q    <= par_q;
`else
                        state_q <= STOP;
                        tx_q    <= 1'b1;
`endif
                    end else begin
                        bit_q <= bit_q + BW'(1);
                        tx_q  <= shift_q[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
endmodule
